// File: rtl/iopmp_cfg_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : iopmp_cfg_loader (with TL-UL type package iopmp_tlul_pkg)
// Brief    : Walks an external command table and replays each entry as a
//            TL-UL PutFullData/Get on the IOPMP control port.
// Revision : 1.0 - initial release
// ============================================================================

package iopmp_tlul_pkg;
    localparam int TL_AW = 32;
    localparam int TL_DW = 32;

    localparam logic [2:0] c_op_put_full = 3'd0;
    localparam logic [2:0] c_op_get      = 3'd4;

    typedef struct packed {
        logic                 a_valid;
        logic [2:0]           a_opcode;
        logic [2:0]           a_param;
        logic [1:0]           a_size;
        logic [7:0]           a_source;
        logic [TL_AW-1:0]     a_address;
        logic [TL_DW/8-1:0]   a_mask;
        logic [TL_DW-1:0]     a_data;
        logic                 d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                 d_valid;
        logic [2:0]           d_opcode;
        logic [2:0]           d_param;
        logic [1:0]           d_size;
        logic [7:0]           d_source;
        logic                 d_sink;
        logic [TL_DW-1:0]     d_data;
        logic                 d_error;
        logic                 a_ready;
    } tl_d2h_t;
endpackage

module iopmp_cfg_loader
    import iopmp_tlul_pkg::*;
#(
    parameter int         NUM_CMDS  = 21,
    parameter logic [7:0] SOURCE_ID = 8'hE7,
    parameter int         TIMEOUT   = 64,
    localparam int        IDX_W     = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    output logic [IDX_W-1:0] cmd_idx_o,
    input  logic             cmd_op_i,
    input  logic [TL_AW-1:0] cmd_addr_i,
    input  logic [TL_DW-1:0] cmd_data_i,
    output tl_h2d_t          mst_req_o,
    input  tl_d2h_t          slv_rsp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [IDX_W-1:0] err_idx_o,
    output logic [TL_DW-1:0] rdata_o,
    output logic             rdata_valid_o
);

    localparam int c_wait_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]    c_idx_last  = IDX_W'(NUM_CMDS - 1);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_req  = 3'd1;
    localparam logic [2:0] c_st_rsp  = 3'd2;
    localparam logic [2:0] c_st_done = 3'd3;
    localparam logic [2:0] c_st_err  = 3'd4;

    localparam logic [1:0] c_ec_none = 2'b00;
    localparam logic [1:0] c_ec_derr = 2'b01;
    localparam logic [1:0] c_ec_a_to = 2'b10;
    localparam logic [1:0] c_ec_d_to = 2'b11;

    logic [2:0]          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [c_wait_w-1:0] r_wait;
    logic                r_req_first;
    logic                r_op;
    logic [TL_AW-1:0]    r_addr;
    logic [TL_DW-1:0]    r_data;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic [IDX_W-1:0]    r_err_idx;
    logic [TL_DW-1:0]    r_rdata;
    logic                r_rdata_valid;

    logic                w_op;
    logic [TL_AW-1:0]    w_addr;
    logic [TL_DW-1:0]    w_data;
    logic                w_unused_rsp;

    // The table answers cmd_idx_o combinationally, so the first REQ cycle
    // forwards it directly while the same edge latches it for the rest of REQ.
    assign w_op   = r_req_first ? cmd_op_i   : r_op;
    assign w_addr = r_req_first ? cmd_addr_i : r_addr;
    assign w_data = r_req_first ? cmd_data_i : r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_idx         <= '0;
            r_wait        <= '0;
            r_req_first   <= 1'b0;
            r_op          <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_err         <= 1'b0;
            r_err_code    <= c_ec_none;
            r_err_idx     <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start_i) begin
                        r_idx       <= '0;
                        r_err       <= 1'b0;
                        r_err_code  <= c_ec_none;
                        r_wait      <= '0;
                        r_req_first <= 1'b1;
                        r_state     <= c_st_req;
                    end
                end
                c_st_req: begin
                    if (r_req_first) begin
                        r_op        <= cmd_op_i;
                        r_addr      <= cmd_addr_i;
                        r_data      <= cmd_data_i;
                        r_req_first <= 1'b0;
                    end
                    if (slv_rsp_i.a_ready) begin
                        r_wait  <= '0;
                        r_state <= c_st_rsp;
                    end else if (r_wait == c_wait_last) begin
                        r_err      <= 1'b1;
                        r_err_code <= c_ec_a_to;
                        r_err_idx  <= r_idx;
                        r_state    <= c_st_err;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                c_st_rsp: begin
                    if (slv_rsp_i.d_valid) begin
                        if (slv_rsp_i.d_error) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_ec_derr;
                            r_err_idx  <= r_idx;
                            r_state    <= c_st_err;
                        end else begin
                            if (r_op) begin
                                r_rdata       <= slv_rsp_i.d_data;
                                r_rdata_valid <= 1'b1;
                            end
                            if (r_idx == c_idx_last) begin
                                r_state <= c_st_done;
                            end else begin
                                r_idx       <= r_idx + 1'b1;
                                r_wait      <= '0;
                                r_req_first <= 1'b1;
                                r_state     <= c_st_req;
                            end
                        end
                    end else if (r_wait == c_wait_last) begin
                        r_err      <= 1'b1;
                        r_err_code <= c_ec_d_to;
                        r_err_idx  <= r_idx;
                        r_state    <= c_st_err;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                // Parking idx at 0 lets the table present command 0 before start.
                c_st_done: begin
                    r_idx   <= '0;
                    r_state <= c_st_idle;
                end
                c_st_err: begin
                    r_idx   <= '0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_comb begin
        mst_req_o           = '0;
        mst_req_o.a_valid   = (r_state == c_st_req);
        mst_req_o.a_opcode  = w_op ? c_op_get : c_op_put_full;
        mst_req_o.a_param   = 3'd0;
        mst_req_o.a_size    = 2'b10;
        mst_req_o.a_source  = SOURCE_ID;
        mst_req_o.a_address = w_addr;
        mst_req_o.a_mask    = '1;
        mst_req_o.a_data    = w_data;
        mst_req_o.d_ready   = (r_state == c_st_rsp);
    end

    assign w_unused_rsp = ^{slv_rsp_i.d_opcode, slv_rsp_i.d_param, slv_rsp_i.d_size,
                            slv_rsp_i.d_source, slv_rsp_i.d_sink};

    assign cmd_idx_o     = r_idx;
    assign busy_o        = (r_state == c_st_req) || (r_state == c_st_rsp);
    assign done_o        = (r_state == c_st_done);
    assign err_o         = r_err;
    assign err_code_o    = r_err_code;
    assign err_idx_o     = r_err_idx;
    assign rdata_o       = r_rdata;
    assign rdata_valid_o = r_rdata_valid;

endmodule

`default_nettype wire

// File: doc/iopmp_cfg_loader.md
IOPMP_CFG_LOADER -- requirements
Module: iopmp_cfg_loader

Interface
REQ-001 Parameter NUM_CMDS, default 21, number of register-programming commands in the sequence (>=1).
REQ-002 Parameter SOURCE_ID, default 8'hE7, TL-UL a_source value driven on every request.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles spent in a wait state before aborting.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start_i  in  1  one-cycle pulse, begins the sequence from index 0.
REQ-007 cmd_idx_o  out  $clog2(NUM_CMDS)  index of the command currently requested from the external table.
REQ-008 cmd_op_i  in  1  command opcode: 0 = PutFullData, 1 = Get.
REQ-009 cmd_addr_i  in  TL_AW  register offset for command cmd_idx_o.
REQ-010 cmd_data_i  in  TL_DW  write data for command cmd_idx_o.
REQ-011 mst_req_o  out  tl_h2d_t  TL-UL request to iopmp_control_port.
REQ-012 slv_rsp_i  in  tl_d2h_t  TL-UL response from iopmp_control_port.
REQ-013 busy_o  out  1  high from the cycle after start accepted until DONE/ERR is entered.
REQ-014 done_o  out  1  one-cycle pulse, whole sequence completed without error.
REQ-015 err_o  out  1  sticky error flag, cleared by the next accepted start_i.
REQ-016 err_code_o  out  2  00 none, 01 d_error, 10 a_ready timeout, 11 d_valid timeout.
REQ-017 err_idx_o  out  $clog2(NUM_CMDS)  index of the failing command.
REQ-018 rdata_o  out  TL_DW  d_data captured from the latest Get response.
REQ-019 rdata_valid_o  out  1  one-cycle pulse, rdata_o updated.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, RSP, DONE, ERR.
REQ-021 IDLE: start_i=1 SHALL clear idx, err_o, err_code_o and move to REQ; start_i in any other state SHALL be ignored.
REQ-022 On entry to REQ, cmd_op_i/cmd_addr_i/cmd_data_i for cmd_idx_o SHALL be registered into the A-channel; a_valid SHALL be high on the first REQ cycle (one cycle after start_i).
REQ-023 A-channel fields: a_opcode per cmd_op_i, a_param 0, a_size 2'b10, a_mask all ones, a_source SOURCE_ID, a_address/a_data registered values; all held stable while a_valid=1.
REQ-024 REQ: a_valid=1 && a_ready=1 SHALL complete the request; next state RSP, a_valid low from the next cycle.
REQ-025 d_ready SHALL be high only in RSP; a response is accepted on d_valid=1 in RSP.
REQ-026 RSP, accepted response with d_error=1: next state ERR, err_code_o=01, err_idx_o=idx.
REQ-027 RSP, accepted response with d_error=0: if command is Get, rdata_o<=d_data and rdata_valid_o pulses next cycle; if idx=NUM_CMDS-1 next state DONE, else idx<=idx+1 and next state REQ (new a_valid the cycle after the response).
REQ-028 A wait counter SHALL clear on entry to REQ and RSP and increment each cycle in those states; reaching TIMEOUT SHALL move to ERR with err_code_o 10 (REQ) or 11 (RSP).
REQ-029 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-030 ERR SHALL set err_o=1 and return to IDLE next cycle; err_o, err_code_o, err_idx_o hold until the next accepted start_i.
REQ-031 idx SHALL never exceed NUM_CMDS-1 (no wrap-around); cmd_idx_o always equals idx.

Reset
REQ-032 Reset SHALL force IDLE, idx 0, a_valid 0, d_ready 0, busy_o 0, done_o 0, err_o 0, err_code_o 0, err_idx_o 0, rdata_o 0, rdata_valid_o 0, regardless of clk.
REQ-033 Reset asserted mid-sequence SHALL abort immediately; after release no request is issued until a new start_i.

Verification
REQ-034 NUM_CMDS=3, all PutFullData (HWCFG0=FFFF0000, MDCFG0=2, ENTRY_ADDR0=20000000), control port responds d_error=0 -> exactly three A handshakes in order, done_o one pulse, err_o 0.
REQ-035 Command 1 is Get of HWCFG0, response d_data=32'h1234_5678 -> rdata_o=12345678, rdata_valid_o one pulse, sequence continues.
REQ-036 Command 1 responds d_error=1 -> no request for index 2, err_o=1, err_code_o=01, err_idx_o=1, done_o never pulses.
REQ-037 a_ready held low -> after TIMEOUT cycles err_code_o=10; d_valid withheld -> err_code_o=11.
REQ-038 start_i pulsed while busy_o=1, and reset asserted between commands -> second start ignored; after reset all outputs at reset values, a_valid stays 0 until next start_i.
